// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared encodings and defaults for the write-back stage and register file
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    typedef enum logic [1:0] {
        MEMTOREG_IMM  = 2'b00,
        MEMTOREG_RAM  = 2'b01,
        MEMTOREG_PC   = 2'b10,
        MEMTOREG_RSVD = 2'b11
    } memtoreg_e;

    typedef enum logic {
        WB_RUN    = 1'b0,
        WB_HALTED = 1'b1
    } wb_state_e;

endpackage

// File: rtl/regfile_2r1w.sv
// rtl/regfile_2r1w.sv - 2-read 1-write register file with r0 hardwired to zero
// Reads are combinational and see the write port in the same cycle (write-through).
module regfile_2r1w
    import mips_pkg::*;
#(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int ADDR_W = mips_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] ra0,
    input  logic [ADDR_W-1:0] ra1,
    output logic [DATA_W-1:0] rd0,
    output logic [DATA_W-1:0] rd1
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (wa != '0)) begin
            regs[wa] <= wd;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] ra);
        if (ra == '0) begin
            return '0;
        end else if (we && (ra == wa)) begin
            return wd;
        end else begin
            return regs[ra];
        end
    endfunction

    always_comb begin
        rd0 = read_port(ra0);
        rd1 = read_port(ra1);
    end

endmodule

// File: rtl/wb_regfile_unit.sv
// rtl/wb_regfile_unit.sv - write-back mux, halt FSM and performance counters around the register file
module wb_regfile_unit
    import mips_pkg::*;
#(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int ADDR_W = mips_pkg::ADDR_W,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] In_RAM_Data,
    input  logic [DATA_W-1:0] In_Immediate_Data,
    input  logic [DATA_W-1:0] In_PC,
    input  logic [ADDR_W-1:0] In_Rd,
    input  logic              In_RegWrite,
    input  logic [1:0]        In_MemtoReg,
    input  logic              In_halt,
    input  logic [ADDR_W-1:0] Rs_Addr,
    input  logic [ADDR_W-1:0] Rt_Addr,
    output logic [DATA_W-1:0] Rs_Data,
    output logic [DATA_W-1:0] Rt_Data,
    output logic [DATA_W-1:0] WB_Data,
    output logic              WB_Write,
    output logic              Halted,
    output logic [CNT_W-1:0]  Write_Count,
    output logic [CNT_W-1:0]  Cycle_Count
);

    wb_state_e state;

    always_comb begin
        WB_Data = '0;
        case (In_MemtoReg)
            MEMTOREG_IMM: WB_Data = In_Immediate_Data;
            MEMTOREG_RAM: WB_Data = In_RAM_Data;
            MEMTOREG_PC:  WB_Data = In_PC;
            default:      WB_Data = '0;
        endcase
    end

    // Writes to r0 are filtered here so they are neither committed nor counted.
    assign WB_Write = In_RegWrite && (In_MemtoReg != MEMTOREG_RSVD) &&
                      (In_Rd != '0) && (state == WB_RUN);

    assign Halted = (state == WB_HALTED);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= WB_RUN;
            Write_Count <= '0;
            Cycle_Count <= '0;
        end else if (state == WB_RUN) begin
            Cycle_Count <= Cycle_Count + 1'b1;
            if (WB_Write) begin
                Write_Count <= Write_Count + 1'b1;
            end
            if (In_halt) begin
                state <= WB_HALTED;
            end
        end
    end

    regfile_2r1w #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clk (clk),
        .rst (rst),
        .we  (WB_Write),
        .wa  (In_Rd),
        .wd  (WB_Data),
        .ra0 (Rs_Addr),
        .ra1 (Rt_Addr),
        .rd0 (Rs_Data),
        .rd1 (Rt_Data)
    );

endmodule

// File: tb/tb_wb_regfile_unit.sv
// tb/tb_wb_regfile_unit.sv - scoreboard bench for wb_regfile_unit against a behavioural model
module tb_wb_regfile_unit;

    logic        clk;
    logic        rst;
    logic [31:0] ram_data, imm_data, pc_data;
    logic [4:0]  rd;
    logic        reg_write;
    logic [1:0]  memtoreg;
    logic        halt;
    logic [4:0]  rs_addr, rt_addr;
    logic [31:0] rs_data, rt_data, wb_data;
    logic        wb_write, halted;
    logic [31:0] write_count, cycle_count;

    wb_regfile_unit dut (
        .clk               (clk),
        .rst               (rst),
        .In_RAM_Data       (ram_data),
        .In_Immediate_Data (imm_data),
        .In_PC             (pc_data),
        .In_Rd             (rd),
        .In_RegWrite       (reg_write),
        .In_MemtoReg       (memtoreg),
        .In_halt           (halt),
        .Rs_Addr           (rs_addr),
        .Rt_Addr           (rt_addr),
        .Rs_Data           (rs_data),
        .Rt_Data           (rt_data),
        .WB_Data           (wb_data),
        .WB_Write          (wb_write),
        .Halted            (halted),
        .Write_Count       (write_count),
        .Cycle_Count       (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] wb;
        logic        wbw;
        logic        hlt;
        logic [31:0] wc;
        logic [31:0] cc;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass = 0;
    int   n_total = 0;
    bit   done = 1'b0;

    // Architectural model: plain array, halt flag and two counters.
    logic [31:0] m_regs [32];
    bit          m_halted;
    logic [31:0] m_wc, m_cc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_halted = 1'b0;
        m_wc = 32'h0;
        m_cc = 32'h0;
    endtask

    function automatic logic [31:0] read_model(input logic [4:0] a, input bit w,
                                               input logic [4:0] d, input logic [31:0] v);
        if (a == 5'd0) return 32'h0;
        if (w && a == d) return v;
        return m_regs[a];
    endfunction

    task automatic step(input bit r, input bit w, input logic [1:0] mt, input logic [4:0] d,
                        input logic [31:0] ram, input logic [31:0] imm, input logic [31:0] pc,
                        input bit h, input logic [4:0] a, input logic [4:0] b);
        exp_t e;
        logic [31:0] val;
        bit commit;
        @(posedge clk);
        #1;
        rst = r; reg_write = w; memtoreg = mt; rd = d;
        ram_data = ram; imm_data = imm; pc_data = pc; halt = h;
        rs_addr = a; rt_addr = b;
        val = (mt == 2'd0) ? imm : (mt == 2'd1) ? ram : (mt == 2'd2) ? pc : 32'h0;
        commit = w && (mt != 2'd3) && (d != 5'd0) && !m_halted;
        e.wb  = val;
        e.wbw = commit;
        e.rs  = read_model(a, commit, d, val);
        e.rt  = read_model(b, commit, d, val);
        e.hlt = m_halted;
        e.wc  = m_wc;
        e.cc  = m_cc;
        exp_q.push_back(e);
        // State as it will be after the coming posedge.
        if (r) begin
            model_clear();
        end else if (!m_halted) begin
            if (commit) begin
                m_regs[d] = val;
                m_wc = m_wc + 1;
            end
            m_cc = m_cc + 1;
            if (h) m_halted = 1'b1;
        end
    endtask

    initial begin : monitor
        exp_t e;
        while (!done) begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rs_data", rs_data, e.rs);
                check("rt_data", rt_data, e.rt);
                check("wb_data", wb_data, e.wb);
                check("wb_write", {31'h0, wb_write}, {31'h0, e.wbw});
                check("halted", {31'h0, halted}, {31'h0, e.hlt});
                check("write_count", write_count, e.wc);
                check("cycle_count", cycle_count, e.cc);
            end
        end
    end

    initial begin : driver
        logic [4:0] d, a, b;
        rst = 1'b1; reg_write = 1'b0; memtoreg = 2'd0; rd = 5'd0;
        ram_data = 32'h0; imm_data = 32'h0; pc_data = 32'h0; halt = 1'b0;
        rs_addr = 5'd0; rt_addr = 5'd0;
        model_clear();
        repeat (2) @(posedge clk);

        step(0, 0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 0, 5'd5, 5'd0);
        step(0, 1, 2'd1, 5'd3, 32'hDEADBEEF, 32'h11, 32'h0, 0, 5'd0, 5'd0);
        step(0, 0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 0, 5'd3, 5'd0);
        step(0, 1, 2'd0, 5'd7, 32'h0, 32'h1234, 32'h0, 0, 5'd7, 5'd7);
        step(0, 1, 2'd0, 5'd0, 32'h0, 32'hFFFF, 32'h0, 0, 5'd0, 5'd4);
        step(0, 1, 2'd3, 5'd4, 32'hAAAA, 32'hBBBB, 32'hCCCC, 0, 5'd4, 5'd0);
        step(0, 0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 0, 5'd4, 5'd0);
        step(0, 1, 2'd2, 5'd31, 32'h1, 32'h2, 32'h40, 1, 5'd31, 5'd0);
        step(0, 1, 2'd0, 5'd2, 32'h0, 32'h55, 32'h0, 0, 5'd31, 5'd2);
        step(0, 0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1, 5'd2, 5'd31);
        step(1, 1, 2'd0, 5'd1, 32'h0, 32'h99, 32'h0, 0, 5'd31, 5'd1);
        step(0, 1, 2'd0, 5'd1, 32'h0, 32'h77, 32'h0, 0, 5'd1, 5'd31);
        step(0, 0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 0, 5'd1, 5'd31);

        for (int i = 0; i < 600; i++) begin
            d = 5'($urandom_range(0, 31));
            a = ($urandom_range(0, 3) == 0) ? d : 5'($urandom_range(0, 31));
            b = ($urandom_range(0, 3) == 0) ? d : 5'($urandom_range(0, 31));
            step($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
                 2'($urandom_range(0, 3)), d, $urandom, $urandom, $urandom,
                 $urandom_range(0, 59) == 0, a, b);
        end

        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
        done = 1'b1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
